// File: rtl/texture_pkg.sv
// Shared widths, defaults and helpers for the texture read arbiter slice.
package texture_pkg;
  localparam int unsigned IDX_W_DEF        = 8;
  localparam int unsigned DATA_W_DEF       = 2048;
  localparam int unsigned N_REQ_DEF        = 4;
  localparam int unsigned READ_LATENCY_DEF = 1;
  localparam int unsigned MAX_REQ          = 8;

  // Population count over the widest supported requester vector.
  function automatic logic [3:0] popcount(input logic [MAX_REQ-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction
endpackage

// File: rtl/tex_rr_picker.sv
// Rotating-priority pick: first valid requester at or after rr_ptr, wrapping.
module tex_rr_picker
  import texture_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  localparam int unsigned PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [PTR_W-1:0] winner,
  output logic             found
);
  logic [PTR_W-1:0] pos;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    pos    = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      pos = PTR_W'((32'(rr_ptr) + i) % N_REQ);
      if (!found && valid[pos]) begin
        winner = pos;
        found  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/texture_read_arbiter.sv
// Round-robin arbiter sharing one texture read port among N_REQ requesters,
// merging same-index requests and returning blocks after the read latency.
module texture_read_arbiter
  import texture_pkg::*;
#(
  parameter int unsigned N_REQ        = N_REQ_DEF,
  parameter int unsigned IDX_W        = IDX_W_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned READ_LATENCY = READ_LATENCY_DEF,
  parameter int unsigned MERGE_EN     = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       i_req_valid,
  input  logic [N_REQ*IDX_W-1:0] i_req_idx,
  output logic [N_REQ-1:0]       o_req_ready,
  input  logic                   i_pause,
  output logic [IDX_W-1:0]       o_tex_idx,
  input  logic [DATA_W-1:0]      i_tex_data,
  output logic [N_REQ-1:0]       o_rsp_valid,
  output logic [IDX_W-1:0]       o_rsp_idx,
  output logic [DATA_W-1:0]      o_rsp_data,
  output logic                   o_busy,
  output logic [15:0]            o_merge_cnt
);
  localparam int unsigned PTR_W = $clog2(N_REQ);

  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   winner;
  logic               found;
  logic [IDX_W-1:0]   idx_arr [N_REQ];
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   last_idx;
  logic [N_REQ-1:0]   hit;
  logic [N_REQ-1:0]   grant;
  logic [MAX_REQ-1:0] grant_ext;
  logic [16:0]        merge_sum;
  logic [N_REQ-1:0]   pipe_mask [READ_LATENCY];
  logic [IDX_W-1:0]   pipe_idx  [READ_LATENCY];
  logic [READ_LATENCY-1:0] stage_busy;

  tex_rr_picker #(.N_REQ(N_REQ)) u_picker (
    .valid  (i_req_valid),
    .rr_ptr (rr_ptr),
    .winner (winner),
    .found  (found)
  );

  assign win_idx = idx_arr[winner];

  // The winner always hits; with merging, any valid requester on the same index joins it.
  for (genvar r = 0; r < N_REQ; r++) begin : g_grant
    assign idx_arr[r] = i_req_idx[r*IDX_W +: IDX_W];
    assign hit[r] = (PTR_W'(r) == winner) ||
                    ((MERGE_EN != 0) && i_req_valid[r] && (idx_arr[r] == win_idx));
  end

  assign grant       = (found && !i_pause) ? hit : '0;
  assign o_req_ready = grant;
  assign o_tex_idx   = (|grant) ? win_idx : last_idx;
  assign grant_ext   = MAX_REQ'(grant);
  assign merge_sum   = {1'b0, o_merge_cnt} + {13'd0, popcount(grant_ext)} - 17'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr      <= '0;
      last_idx    <= '0;
      o_merge_cnt <= '0;
    end else if (|grant) begin
      rr_ptr      <= (winner == PTR_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
      last_idx    <= win_idx;
      o_merge_cnt <= merge_sum[16] ? '1 : merge_sum[15:0];
    end
  end

  for (genvar s = 0; s < READ_LATENCY; s++) begin : g_pipe
    if (s == 0) begin : g_head
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          pipe_mask[s] <= '0;
          pipe_idx[s]  <= '0;
        end else begin
          pipe_mask[s] <= grant;
          pipe_idx[s]  <= o_tex_idx;
        end
      end
    end else begin : g_tail
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          pipe_mask[s] <= '0;
          pipe_idx[s]  <= '0;
        end else begin
          pipe_mask[s] <= pipe_mask[s-1];
          pipe_idx[s]  <= pipe_idx[s-1];
        end
      end
    end
    assign stage_busy[s] = |pipe_mask[s];
  end

  assign o_busy      = |stage_busy;
  assign o_rsp_valid = pipe_mask[READ_LATENCY-1];
  assign o_rsp_idx   = pipe_idx[READ_LATENCY-1];
  assign o_rsp_data  = i_tex_data;
endmodule

// File: tb/tb_texture_read_arbiter.sv
// Bench: three arbiter configurations on shared stimulus, each checked every cycle
// against a queue-based behavioural model, plus hand-computed directed checks.
module tb_texture_read_arbiter;
  logic          clk;
  logic          rst_n;
  logic [3:0]    req_valid;
  logic [31:0]   req_idx;
  logic          pause;
  logic [31:0]   tex_word;
  logic [2047:0] tex_data;

  logic [3:0]    rdy   [3];
  logic [7:0]    tidx  [3];
  logic [3:0]    rv    [3];
  logic [7:0]    ridx  [3];
  logic [2047:0] rdata [3];
  logic          busy  [3];
  logic [15:0]   mcnt  [3];

  int checks;
  int errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Spec-level grant rule: rotate-scan from ptr for the winner, then add equal-index peers.
  function automatic logic [3:0] model_grant(input logic [3:0] v, input logic [31:0] ix,
                                             input bit pz, input int ptr, input int ml,
                                             output int win);
    logic [3:0] gm;
    gm  = 4'b0;
    win = -1;
    if (pz) return gm;
    for (int k = 0; k < 4; k++)
      if (win < 0 && v[(ptr + k) % 4]) win = (ptr + k) % 4;
    if (win < 0) return gm;
    for (int r = 0; r < 4; r++)
      if (r == win || (ml != 0 && v[r] && ix[r*8 +: 8] == ix[win*8 +: 8])) gm[r] = 1'b1;
    return gm;
  endfunction

  typedef struct {
    int         due;
    logic [3:0] mask;
    logic [7:0] idx;
  } flight_t;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned ML = (g == 1) ? 0 : 1;
    localparam int unsigned RL = (g == 2) ? 3 : 1;

    texture_read_arbiter #(
      .N_REQ(4), .IDX_W(8), .DATA_W(2048), .READ_LATENCY(RL), .MERGE_EN(ML)
    ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_req_valid (req_valid),
      .i_req_idx   (req_idx),
      .o_req_ready (rdy[g]),
      .i_pause     (pause),
      .o_tex_idx   (tidx[g]),
      .i_tex_data  (tex_data),
      .o_rsp_valid (rv[g]),
      .o_rsp_idx   (ridx[g]),
      .o_rsp_data  (rdata[g]),
      .o_busy      (busy[g]),
      .o_merge_cnt (mcnt[g])
    );

    int         m_ptr;
    logic [7:0] m_last;
    int         m_cnt;
    int         m_cyc;
    bit         m_ok;
    flight_t    m_q[$];

    // Inputs are stable from posedge+2 through the next posedge, so the model
    // checks and then advances at the negedge as if that next edge had occurred.
    always @(negedge clk) begin
      int         w;
      logic [3:0] eg;
      logic [3:0] ev;
      logic [7:0] ei;
      logic [7:0] wi;
      bit         eb;
      flight_t    f;
      if (!rst_n) begin
        m_ptr  = 0;
        m_last = 8'h00;
        m_cnt  = 0;
        m_cyc  = 0;
        m_q.delete();
        m_ok   = 1'b1;
      end else if (m_ok) begin
        eg = model_grant(req_valid, req_idx, pause, m_ptr, ML, w);
        wi = (w >= 0) ? req_idx[w*8 +: 8] : m_last;
        ev = 4'b0;
        ei = 8'h00;
        eb = 1'b0;
        foreach (m_q[i]) begin
          if (m_q[i].due == m_cyc) begin
            ev = m_q[i].mask;
            ei = m_q[i].idx;
          end
          if (m_q[i].due >= m_cyc) eb = 1'b1;
        end
        chk($sformatf("u%0d ready c%0d", g, m_cyc), {28'd0, rdy[g]}, {28'd0, eg});
        chk($sformatf("u%0d tex_idx c%0d", g, m_cyc), {24'd0, tidx[g]}, {24'd0, wi});
        chk($sformatf("u%0d rsp_valid c%0d", g, m_cyc), {28'd0, rv[g]}, {28'd0, ev});
        if (ev != 4'b0) begin
          chk($sformatf("u%0d rsp_idx c%0d", g, m_cyc), {24'd0, ridx[g]}, {24'd0, ei});
          chk($sformatf("u%0d rsp_data c%0d", g, m_cyc), {31'd0, rdata[g] == tex_data}, 32'd1);
        end
        chk($sformatf("u%0d busy c%0d", g, m_cyc), {31'd0, busy[g]}, {31'd0, eb});
        chk($sformatf("u%0d merge_cnt c%0d", g, m_cyc), {16'd0, mcnt[g]}, m_cnt);
        if (eg != 4'b0) begin
          f.due  = m_cyc + RL;
          f.mask = eg;
          f.idx  = wi;
          m_q.push_back(f);
          m_ptr  = (w + 1) % 4;
          m_last = wi;
          m_cnt  = m_cnt + $countones(eg) - 1;
          if (m_cnt > 65535) m_cnt = 65535;
        end
        while (m_q.size() > 0 && m_q[0].due <= m_cyc) void'(m_q.pop_front());
        m_cyc++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
    tex_word = $urandom;
    tex_data = {64{tex_word}};
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic reset_dut();
    step();
    rst_n     = 1'b0;
    req_valid = 4'b0;
    pause     = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    req_valid = 4'b0;
    req_idx   = 32'h0;
    pause     = 1'b0;
    tex_word  = 32'h0;
    tex_data  = '0;

    // Reset values on all configurations
    reset_dut();
    settle();
    for (int g = 0; g < 3; g++) begin
      chk("reset ready", {28'd0, rdy[g]}, 32'h0);
      chk("reset rsp_valid", {28'd0, rv[g]}, 32'h0);
      chk("reset busy", {31'd0, busy[g]}, 32'h0);
      chk("reset merge_cnt", {16'd0, mcnt[g]}, 32'h0);
      chk("reset tex_idx", {24'd0, tidx[g]}, 32'h0);
    end

    // Single request from r2
    req_valid = 4'b0100;
    req_idx   = 32'h0005_0000;
    settle();
    chk("single ready", {28'd0, rdy[0]}, 32'h4);
    chk("single tex_idx", {24'd0, tidx[0]}, 32'h05);
    step();
    req_valid = 4'b0;
    settle();
    chk("single rsp_valid", {28'd0, rv[0]}, 32'h4);
    chk("single rsp_idx", {24'd0, ridx[0]}, 32'h05);
    chk("single busy", {31'd0, busy[0]}, 32'h1);
    step();
    settle();
    chk("single busy after", {31'd0, busy[0]}, 32'h0);

    // Round-robin with distinct indices
    reset_dut();
    req_valid = 4'b1111;
    req_idx   = 32'h0403_0201;
    for (int k = 0; k < 5; k++) begin
      settle();
      chk($sformatf("rr ready %0d", k), {28'd0, rdy[0]}, 32'h1 << (k % 4));
      chk($sformatf("rr tex_idx %0d", k), {24'd0, tidx[0]}, (k % 4) + 1);
      step();
    end
    req_valid = 4'b0;

    // Merge with rr_ptr=1
    reset_dut();
    req_valid = 4'b0001;
    req_idx   = 32'h0000_0033;
    settle();
    chk("merge prime", {28'd0, rdy[0]}, 32'h1);
    step();
    req_valid = 4'b1011;
    req_idx   = 32'h1000_1020;
    settle();
    chk("merge ready", {28'd0, rdy[0]}, 32'hA);
    chk("merge tex_idx", {24'd0, tidx[0]}, 32'h10);
    chk("nomerge ready", {28'd0, rdy[1]}, 32'h2);
    step();
    req_valid = 4'b0001;
    settle();
    chk("merge next ready", {28'd0, rdy[0]}, 32'h1);
    chk("merge next tex_idx", {24'd0, tidx[0]}, 32'h20);
    chk("merge cnt", {16'd0, mcnt[0]}, 32'h1);
    chk("merge rsp_valid", {28'd0, rv[0]}, 32'hA);
    chk("merge rsp_idx", {24'd0, ridx[0]}, 32'h10);
    step();
    req_valid = 4'b0;
    settle();
    chk("merge rsp2_valid", {28'd0, rv[0]}, 32'h1);
    chk("merge rsp2_idx", {24'd0, ridx[0]}, 32'h20);

    // Same stimulus with merging disabled
    reset_dut();
    req_valid = 4'b0001;
    req_idx   = 32'h0000_0033;
    step();
    req_valid = 4'b1011;
    req_idx   = 32'h1000_1020;
    settle();
    chk("nm ready r1", {28'd0, rdy[1]}, 32'h2);
    step();
    req_valid = 4'b1001;
    settle();
    chk("nm ready r3", {28'd0, rdy[1]}, 32'h8);
    chk("nm tex_idx r3", {24'd0, tidx[1]}, 32'h10);
    step();
    req_valid = 4'b0001;
    settle();
    chk("nm ready r0", {28'd0, rdy[1]}, 32'h1);
    chk("nm tex_idx r0", {24'd0, tidx[1]}, 32'h20);
    step();
    req_valid = 4'b0;
    settle();
    chk("nm merge_cnt", {16'd0, mcnt[1]}, 32'h0);
    chk("nm rsp_valid", {28'd0, rv[1]}, 32'h1);

    // Pause while reads are in flight
    reset_dut();
    req_valid = 4'b0001;
    req_idx   = 32'h0403_0207;
    settle();
    chk("pause grant", {28'd0, rdy[0]}, 32'h1);
    step();
    pause     = 1'b1;
    req_valid = 4'b1111;
    settle();
    chk("pause ready1", {28'd0, rdy[0]}, 32'h0);
    chk("pause rsp_valid", {28'd0, rv[0]}, 32'h1);
    chk("pause ready1 rl3", {28'd0, rdy[2]}, 32'h0);
    step();
    settle();
    chk("pause ready2", {28'd0, rdy[0]}, 32'h0);
    chk("pause busy2", {31'd0, busy[0]}, 32'h0);
    step();
    settle();
    chk("pause rl3 rsp_valid", {28'd0, rv[2]}, 32'h1);
    chk("pause rl3 rsp_idx", {24'd0, ridx[2]}, 32'h07);
    step();
    pause = 1'b0;
    settle();
    chk("pause resume ready", {28'd0, rdy[0]}, 32'h2);
    chk("pause resume tex_idx", {24'd0, tidx[0]}, 32'h02);
    step();
    req_valid = 4'b0;

    // Reset while a READ_LATENCY=3 read is in flight
    reset_dut();
    req_valid = 4'b0010;
    req_idx   = 32'h0000_0900;
    settle();
    chk("midrst grant", {28'd0, rdy[2]}, 32'h2);
    step();
    rst_n     = 1'b0;
    req_valid = 4'b0;
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk($sformatf("midrst rsp_valid %0d", k), {28'd0, rv[2]}, 32'h0);
      chk($sformatf("midrst busy %0d", k), {31'd0, busy[2]}, 32'h0);
      chk($sformatf("midrst tex_idx %0d", k), {24'd0, tidx[2]}, 32'h0);
      chk($sformatf("midrst merge_cnt %0d", k), {16'd0, mcnt[2]}, 32'h0);
      step();
    end
    req_valid = 4'b1111;
    req_idx   = 32'h0403_0201;
    settle();
    chk("midrst ptr", {28'd0, rdy[2]}, 32'h1);
    step();
    req_valid = 4'b0;
    for (int k = 0; k < 4; k++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
